// File: rtl/mem_bridge_3do.sv
// MADAM memory-port bridge: turns single-cycle rd/wr strobes into held req/ack
// external transactions, posting writes through a FIFO. Optional: MEM_BRIDGE_TIMEOUT_EN.
module mem_bridge_3do #(
  parameter int ADDR_W      = 22,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_dout,
  input  logic [3:0]        mem_be,
  input  logic              mem_rd,
  input  logic              mem_wr,
  output logic [31:0]       mem_din,
  output logic              mem_rvalid,
  output logic              mem_busy,
  output logic              proto_err,
  output logic              ext_req,
  output logic              ext_we,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [31:0]       ext_wdata,
  output logic [3:0]        ext_be,
  input  logic              ext_ack,
  input  logic [31:0]       ext_rdata,
  output logic              timeout
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [31:0]       fifo_data [FIFO_DEPTH];
  logic [3:0]        fifo_be   [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count, count_nxt;

  logic [1:0]        state, state_nxt;
  logic              read_pending, rp_nxt;
  logic [ADDR_W-1:0] rd_addr, rd_addr_nxt;

  logic              req_nxt, we_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [31:0]       wdata_nxt, din_nxt;
  logic [3:0]        be_nxt;
  logic              rvalid_nxt, busy_nxt, proto_nxt;

  logic              push, pop, rd_acc, done, expire;
  logic              unused_addr;

  assign unused_addr = ^{mem_addr[1:0], mem_addr[31:ADDR_W+2]};

  // A simultaneous rd+wr keeps the write and drops the read.
  assign push      = mem_wr && !mem_busy;
  assign rd_acc    = mem_rd && !mem_wr && !mem_busy;
  assign proto_nxt = (mem_rd || mem_wr) && (mem_busy || (mem_rd && mem_wr));
  assign done      = ext_req && (ext_ack || expire);

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmo_cnt;

  assign expire = ext_req && !ext_ack && (tmo_cnt == TMO_LAST);

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= expire;
      if (ext_req && !ext_ack && !expire)
        tmo_cnt <= tmo_cnt + 1'b1;
      else
        tmo_cnt <= '0;
    end
  end
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = TIMEOUT_CYC;
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= mem_addr[ADDR_W+1:2];
      fifo_data[wr_ptr] <= mem_dout;
      fifo_be[wr_ptr]   <= mem_be;
    end
  end

  always_comb begin
    state_nxt   = state;
    req_nxt     = ext_req;
    we_nxt      = ext_we;
    addr_nxt    = ext_addr;
    wdata_nxt   = ext_wdata;
    be_nxt      = ext_be;
    rp_nxt      = read_pending;
    rd_addr_nxt = rd_addr;
    rvalid_nxt  = 1'b0;
    din_nxt     = mem_din;
    pop         = 1'b0;

    if (rd_acc) begin
      rp_nxt      = 1'b1;
      rd_addr_nxt = mem_addr[ADDR_W+1:2];
    end

    case (state)
      ST_IDLE: begin
        if (count != '0) begin
          state_nxt = ST_WR;
        end else if (rd_acc || read_pending) begin
          // Empty FIFO: issue the read straight away for two-cycle latency.
          state_nxt = ST_RD;
          req_nxt   = 1'b1;
          we_nxt    = 1'b0;
          addr_nxt  = rd_acc ? mem_addr[ADDR_W+1:2] : rd_addr;
          wdata_nxt = '0;
          be_nxt    = 4'hF;
          rp_nxt    = 1'b0;
        end
      end
      ST_WR: begin
        if (!ext_req) begin
          req_nxt   = 1'b1;
          we_nxt    = 1'b1;
          addr_nxt  = fifo_addr[rd_ptr];
          wdata_nxt = fifo_data[rd_ptr];
          be_nxt    = fifo_be[rd_ptr];
        end else if (done) begin
          pop     = 1'b1;
          req_nxt = 1'b0;
          if (count > CNT_ONE || push)
            state_nxt = ST_WR;
          else if (rp_nxt)
            state_nxt = ST_RD;
          else
            state_nxt = ST_IDLE;
        end
      end
      ST_RD: begin
        if (!ext_req) begin
          req_nxt   = 1'b1;
          we_nxt    = 1'b0;
          addr_nxt  = rd_addr;
          wdata_nxt = '0;
          be_nxt    = 4'hF;
          rp_nxt    = 1'b0;
        end else if (done) begin
          req_nxt    = 1'b0;
          rvalid_nxt = 1'b1;
          din_nxt    = ext_ack ? ext_rdata : 32'hDEADBEEF;
          state_nxt  = ST_RESP;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    count_nxt = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    busy_nxt  = (count_nxt == CNT_FULL) || rp_nxt ||
                (state_nxt == ST_RD) || (state_nxt == ST_RESP);
  end

  // All handshake outputs are registered so they stay stable while ext_req is high.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      read_pending <= 1'b0;
      rd_addr      <= '0;
      ext_req      <= 1'b0;
      ext_we       <= 1'b0;
      ext_addr     <= '0;
      ext_wdata    <= '0;
      ext_be       <= '0;
      mem_din      <= '0;
      mem_rvalid   <= 1'b0;
      mem_busy     <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      state        <= state_nxt;
      count        <= count_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      read_pending <= rp_nxt;
      rd_addr      <= rd_addr_nxt;
      ext_req      <= req_nxt;
      ext_we       <= we_nxt;
      ext_addr     <= addr_nxt;
      ext_wdata    <= wdata_nxt;
      ext_be       <= be_nxt;
      mem_din      <= din_nxt;
      mem_rvalid   <= rvalid_nxt;
      mem_busy     <= busy_nxt;
      proto_err    <= proto_nxt;
    end
  end

endmodule

// File: tb/tb_mem_bridge_3do.sv
// Directed self-checking bench for mem_bridge_3do; the timeout scenario runs
// only when MEM_BRIDGE_TIMEOUT_EN is defined.
module tb_mem_bridge_3do;

  logic        sys_clk = 1'b0;
  logic        reset   = 1'b1;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_dout = '0;
  logic [3:0]  mem_be   = '0;
  logic        mem_rd   = 1'b0;
  logic        mem_wr   = 1'b0;
  logic [31:0] mem_din;
  logic        mem_rvalid, mem_busy, proto_err;
  logic        ext_req, ext_we;
  logic [21:0] ext_addr;
  logic [31:0] ext_wdata;
  logic [3:0]  ext_be;
  logic        ext_ack   = 1'b0;
  logic [31:0] ext_rdata = '0;
  logic        timeout;

  int n_checks = 0;
  int n_fail   = 0;

  mem_bridge_3do #(.ADDR_W(22), .FIFO_DEPTH(4), .TIMEOUT_CYC(8)) dut (
    .sys_clk(sys_clk), .reset(reset),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_be(mem_be),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_din(mem_din), .mem_rvalid(mem_rvalid), .mem_busy(mem_busy),
    .proto_err(proto_err),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_be(ext_be),
    .ext_ack(ext_ack), .ext_rdata(ext_rdata),
    .timeout(timeout)
  );

  always #5 sys_clk = ~sys_clk;

  // Inputs are driven and outputs sampled 1 ns after each rising edge.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(2);
    n_checks++;
    if ({ext_req, ext_we, mem_busy, mem_rvalid, proto_err, timeout} !== 6'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: got %b want 000000",
               {ext_req, ext_we, mem_busy, mem_rvalid, proto_err, timeout});
    end
    n_checks++;
    if (mem_din !== 32'h0 || ext_addr !== 22'h0 || ext_be !== 4'h0 || ext_wdata !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_data: din=%h addr=%h be=%h wdata=%h want all 0",
               mem_din, ext_addr, ext_be, ext_wdata);
    end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_read();
    mem_addr = 32'h0000_0104;
    mem_rd   = 1'b1;
    step();
    mem_rd = 1'b0;
    n_checks++;
    if (ext_req !== 1'b1 || ext_we !== 1'b0 || ext_addr !== 22'h41 || ext_be !== 4'hF) begin
      n_fail++;
      $display("[TB] FAIL read_issue: req=%b we=%b addr=%h be=%h want 1 0 041 f",
               ext_req, ext_we, ext_addr, ext_be);
    end
    n_checks++;
    if (mem_busy !== 1'b1 || mem_rvalid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL read_busy: busy=%b rvalid=%b want 1 0", mem_busy, mem_rvalid);
    end
    ext_ack   = 1'b1;
    ext_rdata = 32'h1234_5678;
    step();
    ext_ack = 1'b0;
    n_checks++;
    if (mem_rvalid !== 1'b1 || mem_din !== 32'h1234_5678 || ext_req !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL read_resp: rvalid=%b din=%h req=%b want 1 12345678 0",
               mem_rvalid, mem_din, ext_req);
    end
    step();
    n_checks++;
    if (mem_rvalid !== 1'b0 || mem_din !== 32'h1234_5678 || mem_busy !== 1'b0 || timeout !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL read_after: rvalid=%b din=%h busy=%b tmo=%b want 0 12345678 0 0",
               mem_rvalid, mem_din, mem_busy, timeout);
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    int k;
    ext_ack = 1'b0;
    mem_be  = 4'hF;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin
        n_checks++;
        if (mem_busy !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL b2b_busy3: busy=%b want 0", mem_busy);
        end
      end
      if (i == 4) begin
        n_checks++;
        if (mem_busy !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL b2b_busy4: busy=%b want 1", mem_busy);
        end
      end
      mem_wr   = 1'b1;
      mem_addr = 32'h0000_1000 + 32'(4 * i);
      mem_dout = 32'hA0 + 32'(i);
      step();
    end
    mem_wr = 1'b0;
    n_checks++;
    if (proto_err !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL b2b_proto: proto_err=%b want 1", proto_err);
    end
    step();
    n_checks++;
    if (proto_err !== 1'b0 || ext_req !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL b2b_hold: proto_err=%b req=%b want 0 1", proto_err, ext_req);
    end
    k = 0;
    for (int c = 0; c < 40; c++) begin
      if (ext_req) begin
        n_checks++;
        if (k > 3 || ext_we !== 1'b1 || ext_addr !== 22'h400 + 22'(k) ||
            ext_wdata !== 32'hA0 + 32'(k) || ext_be !== 4'hF) begin
          n_fail++;
          $display("[TB] FAIL b2b_order%0d: we=%b addr=%h wdata=%h be=%h want 1 %h %h f",
                   k, ext_we, ext_addr, ext_wdata, ext_be, 22'h400 + 22'(k), 32'hA0 + 32'(k));
        end
        k++;
        ext_ack = 1'b1;
      end else begin
        ext_ack = 1'b0;
      end
      step();
    end
    ext_ack = 1'b0;
    n_checks++;
    if (k !== 4 || mem_busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL b2b_count: writes=%0d busy=%b want 4 0", k, mem_busy);
    end
  endtask

  task automatic test_write_then_read();
    int txn, wr_cyc, rv_cnt;
    mem_wr   = 1'b1;
    mem_addr = 32'h0000_0200;
    mem_dout = 32'h0000_00AA;
    mem_be   = 4'b0101;
    step();
    mem_wr = 1'b0;
    n_checks++;
    if (mem_busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL wr_rd_busy: busy=%b want 0", mem_busy);
    end
    mem_rd = 1'b1;
    step();
    mem_rd    = 1'b0;
    ext_rdata = 32'h0000_0055;
    txn = 0; wr_cyc = -1; rv_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (mem_rvalid) begin
        rv_cnt++;
        n_checks++;
        if (mem_din !== 32'h55) begin
          n_fail++;
          $display("[TB] FAIL wr_rd_din: din=%h want 00000055", mem_din);
        end
      end
      if (ext_req) begin
        n_checks++;
        if (txn == 0) begin
          wr_cyc = c;
          if (ext_we !== 1'b1 || ext_addr !== 22'h80 || ext_wdata !== 32'hAA || ext_be !== 4'b0101) begin
            n_fail++;
            $display("[TB] FAIL wr_rd_write: we=%b addr=%h wdata=%h be=%b want 1 080 000000aa 0101",
                     ext_we, ext_addr, ext_wdata, ext_be);
          end
        end else if (ext_we !== 1'b0 || ext_addr !== 22'h80 || txn != 1 || c < wr_cyc + 2) begin
          n_fail++;
          $display("[TB] FAIL wr_rd_read: we=%b addr=%h txn=%0d cyc=%0d wr_ack_cyc=%0d want 0 080 1 >=wr+2",
                   ext_we, ext_addr, txn, c, wr_cyc);
        end
        txn++;
        ext_ack = 1'b1;
      end else begin
        ext_ack = 1'b0;
      end
      step();
    end
    ext_ack = 1'b0;
    n_checks++;
    if (txn !== 2 || rv_cnt !== 1) begin
      n_fail++;
      $display("[TB] FAIL wr_rd_count: txns=%0d rvalids=%0d want 2 1", txn, rv_cnt);
    end
  endtask

  task automatic test_rd_wr_same();
    int reqs, wrs, rvs, perr;
    mem_rd   = 1'b1;
    mem_wr   = 1'b1;
    mem_addr = 32'h0000_0300;
    mem_dout = 32'h0000_0077;
    mem_be   = 4'hF;
    step();
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    reqs = 0; wrs = 0; rvs = 0; perr = 0;
    for (int c = 0; c < 20; c++) begin
      if (proto_err) perr++;
      if (mem_rvalid) rvs++;
      if (ext_req) begin
        reqs++;
        if (ext_we && ext_addr == 22'hC0 && ext_wdata == 32'h77) wrs++;
        ext_ack = 1'b1;
      end else begin
        ext_ack = 1'b0;
      end
      step();
    end
    ext_ack = 1'b0;
    n_checks++;
    if (reqs !== 1 || wrs !== 1 || rvs !== 0 || perr !== 1) begin
      n_fail++;
      $display("[TB] FAIL rdwr_same: reqs=%0d writes=%0d rvalids=%0d proto=%0d want 1 1 0 1",
               reqs, wrs, rvs, perr);
    end
  endtask

  task automatic test_reset_mid();
    int reqs;
    ext_ack = 1'b0;
    mem_be  = 4'hF;
    for (int i = 0; i < 3; i++) begin
      mem_wr   = 1'b1;
      mem_addr = 32'h0000_2000 + 32'(4 * i);
      mem_dout = 32'h100 + 32'(i);
      step();
    end
    mem_wr = 1'b0;
    for (int c = 0; c < 10 && !ext_req; c++) step();
    n_checks++;
    if (ext_req !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_req: req=%b want 1 before reset", ext_req);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (ext_req !== 1'b0 || mem_busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_async: req=%b busy=%b want 0 0", ext_req, mem_busy);
    end
    #1 reset = 1'b0;
    step();
    reqs = 0;
    for (int c = 0; c < 15; c++) begin
      if (ext_req) reqs++;
      ext_ack = ext_req;
      step();
    end
    ext_ack = 1'b0;
    n_checks++;
    if (reqs !== 0) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_quiet: reqs=%0d want 0", reqs);
    end
    mem_rd   = 1'b1;
    mem_addr = 32'h0000_0040;
    step();
    mem_rd = 1'b0;
    n_checks++;
    if (ext_req !== 1'b1 || ext_we !== 1'b0 || ext_addr !== 22'h10) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_new: req=%b we=%b addr=%h want 1 0 010", ext_req, ext_we, ext_addr);
    end
    ext_ack   = 1'b1;
    ext_rdata = 32'hCAFE_0001;
    step();
    ext_ack = 1'b0;
    n_checks++;
    if (mem_rvalid !== 1'b1 || mem_din !== 32'hCAFE_0001) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_data: rvalid=%b din=%h want 1 cafe0001", mem_rvalid, mem_din);
    end
    idle(2);
  endtask

`ifdef MEM_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    int req_cyc;
    bit seen;
    ext_ack  = 1'b0;
    mem_rd   = 1'b1;
    mem_addr = 32'h0000_0500;
    step();
    mem_rd  = 1'b0;
    req_cyc = 0;
    seen    = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (timeout) begin
        seen = 1'b1;
        n_checks++;
        if (req_cyc !== 8 || mem_rvalid !== 1'b1 || mem_din !== 32'hDEADBEEF || ext_req !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL tmo_resp: reqcyc=%0d rvalid=%b din=%h req=%b want 8 1 deadbeef 0",
                   req_cyc, mem_rvalid, mem_din, ext_req);
        end
      end else begin
        if (ext_req) req_cyc++;
        step();
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("[TB] FAIL tmo_seen: timeout=0 want pulse within 40 cycles");
    end
    step();
    n_checks++;
    if (timeout !== 1'b0 || mem_busy !== 1'b0 || ext_req !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL tmo_idle: tmo=%b busy=%b req=%b want 0 0 0", timeout, mem_busy, ext_req);
    end
    idle(2);
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_back_to_back();
    test_write_then_read();
    test_rd_wr_same();
    test_reset_mid();
`ifdef MEM_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
